// File: rtl/spi_reg_bridge.sv
// SPI mode-0 write-only register bridge.
// Decodes 16-bit frames {wr, addr[6:0], data[7:0]} into five 8-bit control
// registers. The SPI pins are asynchronous to clk and are synchronised here.
`timescale 1ns/1ps
module spi_reg_bridge #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_hist, ncs_hist;
  // Fills with ones after reset; ncs edges are trusted only once both the
  // synchroniser and the history flop hold real pad samples. Without this,
  // the idle-high reset value of the ncs chain would fake an ncs_fall when
  // reset releases in the middle of a frame.
  logic [SYNC_STAGES:0]   primed;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  state_t      state;
  logic        armed;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [6:0]  commit_addr;
  logic [7:0]  commit_data;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_fall  = primed[SYNC_STAGES] & ~ncs_s & ncs_hist;
  assign ncs_rise  = primed[SYNC_STAGES] & ncs_s & ~ncs_hist;

  // Synchronise the SPI pins and keep one history flop for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
      primed    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_s;
      ncs_hist  <= ncs_s;
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM: shift bits while selected, decide on ncs_rise, write in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      armed           <= 1'b0;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      commit_addr     <= '0;
      commit_data     <= '0;
      wr_strobe       <= 1'b0;
      frame_err       <= 1'b0;
      // NOTE: the register file is reset explicitly; downstream logic relies on all-zero after reset.
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state     <= SHIFT;
            armed     <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            // End of frame wins over a coincident sclk edge.
            state       <= COMMIT;
            armed       <= 1'b0;
            commit_addr <= shift_reg[14:8];
            commit_data <= shift_reg[7:0];
            if (armed) begin
              wr_strobe <= (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);
              frame_err <= (bit_cnt != 5'd16);
            end
          end else if (sclk_rise && !ncs_s) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (wr_strobe) begin
            case (commit_addr)
              7'd0:    en_reg_out_7_0  <= commit_data;
              7'd1:    en_reg_out_15_8 <= commit_data;
              7'd2:    en_reg_pwm_7_0  <= commit_data;
              7'd3:    en_reg_pwm_15_8 <= commit_data;
              7'd4:    pwm_duty_cycle  <= commit_data;
              default: ;
            endcase
          end
          if (ncs_fall) begin
            state     <= SHIFT;
            armed     <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
